// File: rtl/cpld_reg_bank.sv
// LPC I/O register bank: read-only ID at offset 0, W1C status register, R/W registers.
// Define CPLD_REG_WRLOCK_EN to add the A5/5A write-unlock key sequence with a timed window.
module cpld_reg_bank #(
  parameter int          NUM_REGS      = 32,
  parameter logic [7:0]  ID_VALUE      = 8'h00,
  parameter logic [7:0]  RW_RST        = 8'h00,
  parameter logic [7:0]  STAT_ADDR     = 8'h1E,
  parameter logic [7:0]  KEY_ADDR      = 8'h1F,
  parameter logic [15:0] UNLOCK_CYCLES = 16'd1023
) (
  input  logic                  Mclk,
  input  logic                  MainResetN,
  input  logic [15:0]           DevAddr,
  input  logic                  RdDev_En,
  input  logic                  WrDev_En,
  input  logic [7:0]            WrDev_Data,
  input  logic [7:0]            StatSet,
  output logic [7:0]            RdDev_Data,
  output logic [NUM_REGS*8-1:0] RegOut,
  output logic                  WrLocked
);

  logic [7:0] regs [NUM_REGS];
  logic [7:0] view [NUM_REGS];
  logic [7:0] addr;
  int         addrInt;
  logic       hit;
  logic       wrHit;
  logic       wrStat;
  logic       rwTarget;
  logic       rwWrite;
  logic [7:0] statClr;
  logic [7:0] rdMux;
  logic [7:0] unusedHighAddr;

  assign addr           = DevAddr[7:0];
  assign addrInt        = int'(addr);
  assign unusedHighAddr = DevAddr[15:8];
  assign hit            = {1'b0, addr} < 9'(NUM_REGS);
  assign wrHit          = WrDev_En && hit;
  assign wrStat         = wrHit && (addr == STAT_ADDR);
  assign statClr        = wrStat ? WrDev_Data : 8'h00;

`ifdef CPLD_REG_WRLOCK_EN
  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    KEY1     = 2'b01,
    UNLOCKED = 2'b10
  } lockStateT;

  lockStateT   lockState;
  logic [15:0] timer;
  logic        wrKey;

  assign wrKey    = wrHit && (addr == KEY_ADDR);
  assign rwTarget = (addr != 8'h00) && (addr != STAT_ADDR) && (addr != KEY_ADDR);
  // The window stays open through the cycle where the timer reads zero.
  assign rwWrite  = wrHit && rwTarget && (lockState == UNLOCKED);
  assign WrLocked = (lockState != UNLOCKED);

  always_ff @(posedge Mclk) begin
    if (!MainResetN) begin
      lockState <= LOCKED;
      timer     <= 16'd0;
    end else begin
      case (lockState)
        LOCKED: begin
          if (wrKey && (WrDev_Data == 8'hA5))
            lockState <= KEY1;
        end
        KEY1: begin
          if (wrKey && (WrDev_Data == 8'h5A)) begin
            lockState <= UNLOCKED;
            timer     <= UNLOCK_CYCLES;
          end else if (wrHit) begin
            lockState <= LOCKED;
          end
        end
        UNLOCKED: begin
          if (wrKey || (timer == 16'd0)) begin
            lockState <= LOCKED;
            timer     <= 16'd0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          lockState <= LOCKED;
          timer     <= 16'd0;
        end
      endcase
    end
  end

  // The key offset reads back the lock state rather than stored data.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = regs[i];
      if (i == int'(KEY_ADDR))
        view[i] = {6'b0, lockState};
    end
  end
`else
  logic [23:0] unusedLockParams;

  assign unusedLockParams = {KEY_ADDR, UNLOCK_CYCLES};
  assign rwTarget         = (addr != 8'h00) && (addr != STAT_ADDR);
  assign rwWrite          = wrHit && rwTarget;
  assign WrLocked         = 1'b0;

  always_comb begin
    view = regs;
  end
`endif

  // Status bits: hardware set has priority over a same-cycle write-1 clear.
  always_ff @(posedge Mclk) begin
    if (!MainResetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0)
          regs[i] <= ID_VALUE;
        else if (i == int'(STAT_ADDR))
          regs[i] <= 8'h00;
        else
          regs[i] <= RW_RST;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i == int'(STAT_ADDR))
          regs[i] <= (regs[i] & ~statClr) | StatSet;
        else if (rwWrite && (addrInt == i))
          regs[i] <= WrDev_Data;
      end
    end
  end

  always_comb begin
    rdMux = 8'hFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addrInt == i)
        rdMux = view[i];
    end
  end

  always_ff @(posedge Mclk) begin
    if (!MainResetN)
      RdDev_Data <= 8'hFF;
    else if (RdDev_En)
      RdDev_Data <= rdMux;
  end

  always_comb begin
    RegOut = '0;
    for (int i = 0; i < NUM_REGS; i++)
      RegOut[8*i +: 8] = view[i];
  end

endmodule

// File: tb/tb_cpld_reg_bank.sv
// Self-checking bench for cpld_reg_bank: per-cycle model comparison plus directed literal checks.
module tb_cpld_reg_bank;

  localparam int          NumRegs      = 32;
  localparam logic [7:0]  IdValue      = 8'hC3;
  localparam logic [7:0]  RwRst        = 8'h00;
  localparam int          StatAddr     = 8'h1E;
  localparam int          KeyAddr      = 8'h1F;
  localparam logic [15:0] UnlockCycles = 16'd4;
`ifdef CPLD_REG_WRLOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic                  Mclk;
  logic                  MainResetN;
  logic [15:0]           DevAddr;
  logic                  RdDev_En;
  logic                  WrDev_En;
  logic [7:0]            WrDev_Data;
  logic [7:0]            StatSet;
  logic [7:0]            RdDev_Data;
  logic [NumRegs*8-1:0]  RegOut;
  logic                  WrLocked;

  cpld_reg_bank #(
    .NUM_REGS      (NumRegs),
    .ID_VALUE      (IdValue),
    .RW_RST        (RwRst),
    .STAT_ADDR     (8'h1E),
    .KEY_ADDR      (8'h1F),
    .UNLOCK_CYCLES (UnlockCycles)
  ) dut (
    .Mclk       (Mclk),
    .MainResetN (MainResetN),
    .DevAddr    (DevAddr),
    .RdDev_En   (RdDev_En),
    .WrDev_En   (WrDev_En),
    .WrDev_Data (WrDev_Data),
    .StatSet    (StatSet),
    .RdDev_Data (RdDev_Data),
    .RegOut     (RegOut),
    .WrLocked   (WrLocked)
  );

  initial Mclk = 1'b0;
  always #15 Mclk = ~Mclk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: key progress as a stage flag, unlock as a count of remaining writable cycles.
  logic [7:0] mReg [NumRegs];
  logic [7:0] mStat;
  logic [7:0] mRd;
  int         keyStage;
  int         windowLeft;
  bit         modelValid = 1'b0;

  function automatic logic [7:0] modelRead(input int a);
    if (a >= NumRegs) return 8'hFF;
    if (LockEn && a == KeyAddr) return (windowLeft > 0) ? 8'h02 : ((keyStage == 1) ? 8'h01 : 8'h00);
    if (a == StatAddr) return mStat;
    return mReg[a];
  endfunction

  always @(posedge Mclk) begin : modelProc
    int a;
    bit touched;
    if (!MainResetN) begin
      for (int i = 0; i < NumRegs; i++) mReg[i] = (i == 0) ? IdValue : RwRst;
      mStat      = 8'h00;
      mRd        = 8'hFF;
      keyStage   = 0;
      windowLeft = 0;
      modelValid = 1'b1;
    end else begin
      a       = int'(DevAddr[7:0]);
      touched = 1'b0;
      if (RdDev_En) mRd = modelRead(a);
      if (WrDev_En && a < NumRegs) begin
        if (LockEn && keyStage == 1 && !(a == KeyAddr && WrDev_Data == 8'h5A)) begin
          keyStage = 0;
          if (a == StatAddr) mStat = mStat & ~WrDev_Data;
        end else if (a == StatAddr) begin
          mStat = mStat & ~WrDev_Data;
        end else if (LockEn && a == KeyAddr) begin
          if (keyStage == 1) begin
            keyStage   = 0;
            windowLeft = int'(UnlockCycles) + 1;
            touched    = 1'b1;
          end else if (windowLeft > 0) begin
            windowLeft = 0;
            touched    = 1'b1;
          end else if (WrDev_Data == 8'hA5) begin
            keyStage = 1;
          end
        end else if (a != 0 && (!LockEn || windowLeft > 0)) begin
          mReg[a] = WrDev_Data;
        end
      end
      mStat = mStat | StatSet;
      if (windowLeft > 0 && !touched) windowLeft--;
    end
  end

  always @(negedge Mclk) begin : compareProc
    logic [255:0] flat;
    if (modelValid) begin
      flat = '0;
      for (int i = 0; i < NumRegs; i++) flat[8*i +: 8] = modelRead(i);
      checkOutput("cycRdData", 256'(RdDev_Data), 256'(mRd));
      checkOutput("cycWrLocked", 256'(WrLocked), 256'(LockEn ? (windowLeft == 0) : 1'b0));
      checkOutput("cycRegOut", 256'(RegOut), flat);
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] ss);
    RdDev_En   = rd;
    WrDev_En   = wr;
    DevAddr    = {8'h00, a};
    WrDev_Data = d;
    StatSet    = ss;
    @(negedge Mclk);
    RdDev_En = 1'b0;
    WrDev_En = 1'b0;
    StatSet  = 8'h00;
  endtask

  task automatic readCheck(input string name, input logic [7:0] a, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, a, 8'h00, 8'h00);
    checkOutput(name, 256'(RdDev_Data), 256'(exp));
  endtask

  initial begin
    // Strobes and StatSet held active through reset must be ignored.
    MainResetN = 1'b0;
    RdDev_En   = 1'b1;
    WrDev_En   = 1'b1;
    DevAddr    = 16'h0005;
    WrDev_Data = 8'hAA;
    StatSet    = 8'hFF;
    repeat (3) @(negedge Mclk);
    MainResetN = 1'b1;
    RdDev_En   = 1'b0;
    WrDev_En   = 1'b0;
    StatSet    = 8'h00;
    checkOutput("rstRdData", 256'(RdDev_Data), 256'(8'hFF));
    checkOutput("rstWrLocked", 256'(WrLocked), 256'(LockEn));
    checkOutput("rstId", 256'(RegOut[7:0]), 256'(IdValue));
    checkOutput("rstReg05", 256'(RegOut[47:40]), 256'(8'h00));

    readCheck("rd00", 8'h00, IdValue);
    readCheck("rd05", 8'h05, 8'h00);
    readCheck("rd1E", 8'h1E, 8'h00);
    readCheck("rd40", 8'h40, 8'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("rdHold", 256'(RdDev_Data), 256'(8'hFF));

    applyStimulus(1'b0, 1'b1, 8'h00, 8'h5D, 8'h00);
    readCheck("roId", 8'h00, IdValue);

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h81);
    applyStimulus(1'b0, 1'b1, 8'h1E, 8'h01, 8'h00);
    readCheck("w1cClr0", 8'h1E, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h1E, 8'h80, 8'h80);
    readCheck("w1cSetWins", 8'h1E, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h1E, 8'h80, 8'h00);
    readCheck("w1cClr7", 8'h1E, 8'h00);

`ifdef CPLD_REG_WRLOCK_EN
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h3C, 8'h00);
    readCheck("lockedWr", 8'h05, 8'h00);
    checkOutput("lockedFlag", 256'(WrLocked), 256'(1'b1));
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00);
    readCheck("keyStage1", 8'h1F, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'h5A, 8'h00);
    readCheck("keyOpen", 8'h1F, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h3C, 8'h00);
    readCheck("unlockedWr", 8'h05, 8'h3C);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("relocked", 256'(WrLocked), 256'(1'b1));

    applyStimulus(1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h77, 8'h00);
    readCheck("abortKey", 8'h1F, 8'h00);
    readCheck("abortReg", 8'h05, 8'h3C);

    applyStimulus(1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'h5A, 8'h00);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h07, 8'h11, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h08, 8'h22, 8'h00);
    readCheck("lastCycleWr", 8'h07, 8'h11);
    readCheck("expiredWr", 8'h08, 8'h00);
    checkOutput("expiredFlag", 256'(WrLocked), 256'(1'b1));

    applyStimulus(1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'h5A, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h07, 8'h55, 8'h00);
    checkOutput("rdBeforeWr", 256'(RdDev_Data), 256'(8'h11));
    readCheck("rdAfterWr", 8'h07, 8'h55);

    applyStimulus(1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'h5A, 8'h00);
    MainResetN = 1'b0;
    @(negedge Mclk);
    MainResetN = 1'b1;
    checkOutput("rstMidUnlock", 256'(WrLocked), 256'(1'b1));
    readCheck("rstKeyCode", 8'h1F, 8'h00);
`else
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h12, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h1F, 8'h12, 8'h00);
    readCheck("plainWr05", 8'h05, 8'h12);
    readCheck("plainWr1F", 8'h1F, 8'h12);
    checkOutput("noLockFlag", 256'(WrLocked), 256'(1'b0));
    applyStimulus(1'b1, 1'b1, 8'h05, 8'h99, 8'h00);
    checkOutput("rdBeforeWr", 256'(RdDev_Data), 256'(8'h12));
    readCheck("rdAfterWr", 8'h05, 8'h99);
    MainResetN = 1'b0;
    @(negedge Mclk);
    MainResetN = 1'b1;
    readCheck("rstRestores", 8'h05, RwRst);
`endif

    applyStimulus(1'b0, 1'b1, 8'h40, 8'h66, 8'h00);
    readCheck("oorWr", 8'h40, 8'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cpld_reg_bank.md
CPLD_REG_BANK -- requirements
Module: cpld_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 32, meaning number of 8-bit registers at offsets 0..NUM_REGS-1, legal range 4..128.
REQ-002 Parameter ID_VALUE, default 8'h00, meaning read-only content of offset 0x00.
REQ-003 Parameter RW_RST, default 8'h00, meaning reset value of every R/W register.
REQ-004 Parameter STAT_ADDR, default 8'h1E, meaning offset of the write-1-to-clear status register.
REQ-005 Parameter KEY_ADDR, default 8'h1F, meaning offset of the write-unlock key register.
REQ-006 Parameter UNLOCK_CYCLES, default 16'd1023, meaning length of the unlock window in Mclk cycles.
REQ-007 Mclk  in  1  LPC 33 MHz clock; the only clock.
REQ-008 MainResetN  in  1  reset, synchronous to Mclk, active-low.
REQ-009 DevAddr  in  16  I/O address; only DevAddr[7:0] is decoded.
REQ-010 RdDev_En  in  1  one-cycle I/O read strobe.
REQ-011 WrDev_En  in  1  one-cycle I/O write strobe.
REQ-012 WrDev_Data  in  8  write data byte.
REQ-013 StatSet  in  8  per-bit hardware event pulses into the status register.
REQ-014 RdDev_Data  out  8  registered read data.
REQ-015 RegOut  out  NUM_REGS*8  flattened register contents; offset n occupies bits [8n+7:8n].
REQ-016 WrLocked  out  1  high when writes to R/W registers are blocked.

Function
REQ-017 Hit: address is in range when DevAddr[7:0] < NUM_REGS; out-of-range writes are ignored.
REQ-018 Read: RdDev_En with an in-range address loads RdDev_Data with the addressed register on the next Mclk edge (latency 1).
REQ-019 Read: RdDev_En with an out-of-range address loads RdDev_Data with 8'hFF.
REQ-020 Read: without RdDev_En, RdDev_Data holds its value.
REQ-021 Read of KEY_ADDR returns {6'b0, lock FSM state code}, with LOCKED=00, KEY1=01, UNLOCKED=10.
REQ-022 Offset 0x00 is read-only; writes to it are ignored.
REQ-023 R/W register write: all offsets other than 0x00, STAT_ADDR and KEY_ADDR load WrDev_Data on the next edge, only when WrLocked=0.
REQ-024 STAT_ADDR: each bit is set by StatSet[i]=1 and cleared by a write of 1 in that bit position; writes of 0 leave the bit unchanged.
REQ-025 STAT_ADDR: if set and clear hit the same bit in the same cycle, set wins; STAT_ADDR writes are never blocked by the lock.
REQ-026 Simultaneous read and write to the same offset: read returns the pre-write value.
REQ-027 Lock FSM, LOCKED: a write of 8'hA5 to KEY_ADDR moves to KEY1; any other write to KEY_ADDR stays LOCKED.
REQ-028 Lock FSM, KEY1: a write of 8'h5A to KEY_ADDR moves to UNLOCKED and loads the timer with UNLOCK_CYCLES.
REQ-029 Lock FSM, KEY1: any other write to any in-range offset returns to LOCKED, and that write is not performed.
REQ-030 Lock FSM, UNLOCKED: the timer decrements by 1 each cycle; at timer=0, or on any write to KEY_ADDR, the FSM moves to LOCKED.
REQ-031 Lock FSM, UNLOCKED: the timer does not reload on register writes.
REQ-032 A R/W write in the same cycle that the timer reaches 0 is accepted.
REQ-033 WrLocked is 1 in LOCKED and KEY1, and 0 in UNLOCKED.
REQ-034 RegOut reflects register contents combinationally from flops, with no added latency.

Reset
REQ-035 While MainResetN=0 at an Mclk edge: RdDev_Data=8'hFF, offset 0=ID_VALUE, R/W registers=RW_RST, STAT register=8'h00, FSM=LOCKED, timer=0.
REQ-036 Under reset, all strobes and StatSet are ignored.
REQ-037 Reset asserted mid-unlock forces LOCKED on the same edge.

Configuration
REQ-038 Macro CPLD_REG_WRLOCK_EN: when defined, the lock FSM and timer exist as specified in REQ-021 and REQ-027..REQ-033.
REQ-039 Without CPLD_REG_WRLOCK_EN: no FSM or timer is instantiated; WrLocked is tied to 0; KEY_ADDR is a plain R/W register with reset value RW_RST.

Verification
REQ-040 Reset then read: read 0x00, 0x05, 0x1E, 0x40 -> RdDev_Data = ID_VALUE, 8'h00, 8'h00, 8'hFF, each one cycle after its strobe.
REQ-041 Locked write: write 8'h3C to 0x05 with no key -> read 0x05 returns 8'h00 and WrLocked=1; write A5 then 5A to 0x1F, then write 3C to 0x05 -> read returns 8'h3C.
REQ-042 Key abort: write A5 to 0x1F, then 77 to 0x05 -> FSM LOCKED, 0x05 unchanged, read 0x1F = 8'h00.
REQ-043 Timeout: unlock with UNLOCK_CYCLES=4; write on the cycle the timer reaches 0 is accepted; write one cycle later is rejected and WrLocked=1.
REQ-044 W1C: pulse StatSet=8'h81, then write 8'h01 to 0x1E -> read returns 8'h80; drive StatSet[7]=1 with a simultaneous write of 8'h80 -> bit 7 stays 1.
REQ-045 Macro off: write 8'h12 to 0x05 and to 0x1F with no key -> both read back 8'h12 and WrLocked=0.
